whack_a_mole_game: RTL and testbench
====================================

Name: whack_a_mole_game

Overview:
- Game-logic producer for the VGA whack-a-mole display. Chooses the active mole from a free-running LFSR and times each mole window.
- Detects player whacks on four buttons and keeps score and miss count. Ends the game after a fixed number of misses.
- Its mole_index and mole_visible outputs drive the VGA renderer directly. Score and game state go to the HEX/LED status logic.

Parameters:
- MOLE_CYCLES, 50000000, clock cycles a mole stays up (1 s at 50 MHz); minimum 2.
- GAP_CYCLES, 12500000, blank cycles after a hit or miss before the next mole; minimum 1.
- MAX_MISSES, 3, misses that end the game; range 1..7.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, the only clock.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  raw button, active-high, asynchronous to CLOCK_50.
- whack  in  4  raw buttons, active-high, asynchronous; bit i whacks mole i.
- mole_index  out  2  current mole position 0..3.
- mole_visible  out  1  high while a mole is up.
- score  out  8  hit count, saturating at 255.
- misses  out  3  miss count.
- game_over  out  1  high in OVER state.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous and active-high.
- Reset values: mole_index=0, mole_visible=0, score=0, misses=0, game_over=0, state=IDLE, lfsr=LFSR_SEED. Counters and synchronizers clear to 0.
- Input conditioning:
  - start and each whack bit pass through a 2-FF synchronizer, then a rising-edge detector (sync & ~sync_d).
  - A pin first sampled high at edge N produces an internal pulse during cycle N+2. The resulting state change is visible after edge N+3.
  - Held buttons produce exactly one pulse.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11. Shifts every cycle in all states, including IDLE.
  - Never reaches zero.
- Next-mole rule: cand = lfsr[1:0]. If cand == current mole_index, next = cand+1 mod 4. Consecutive moles therefore never repeat.
- Timer: a single down-counter, loaded with MOLE_CYCLES-1 or GAP_CYCLES-1. An event fires when it reaches 0.
- State machine:
  - IDLE:
    - mole_visible=0.
    - On start pulse: score=0, misses=0, mole_index=next-mole, timer=MOLE_CYCLES-1, go to SHOW.
  - SHOW (mole_visible=1):
    - Hit: whack pulse on bit mole_index, regardless of other bits that same cycle. score+1 (saturating at 255), timer=GAP_CYCLES-1, go to GAP.
    - Wrong press: whack pulse on any other bit with no hit. Counts as a miss.
    - Timeout: timer==0 with no hit. Counts as a miss.
    - A miss does misses+1. If the new value == MAX_MISSES, go to OVER. Otherwise timer=GAP_CYCLES-1 and go to GAP.
    - A hit and a timeout in the same cycle count as a hit.
    - Wrong press and timeout in the same cycle count as one miss.
  - GAP:
    - mole_visible=0; whack pulses are ignored.
    - At timer==0: mole_index=next-mole, timer=MOLE_CYCLES-1, go to SHOW.
  - OVER:
    - game_over=1, mole_visible=0. score and misses are held.
    - A start pulse behaves as the start pulse in IDLE (new game, game_over=0).
  - Start pulse in SHOW or GAP is ignored.
- mole_index changes only when entering SHOW and is held in GAP and OVER.
- All outputs are registered.
- Asserting reset mid-game returns to IDLE with reset values on the next evaluation, with no clock edge needed. After deassertion, a new start pulse is required.

Test Plan:
- Bench parameters for all scenarios: MOLE_CYCLES=20, GAP_CYCLES=4, MAX_MISSES=3.
- Reset during SHOW with score=5: outputs go to reset values before the next CLOCK_50 edge. After release, whack presses leave score=0 until start.
- Start pulse from IDLE: mole_visible rises 3 edges after start is sampled high. mole_index equals the LFSR-derived value. score=0, misses=0.
- Correct whack 5 cycles into SHOW: score 0->1 exactly 3 edges after sampling. mole_visible=0 for 4 cycles. The new mole_index differs from the old one.
- Button held high for 100 cycles across several moles: score increments by at most 1.
- No presses: each mole lasts 20 cycles, misses goes 1,2,3. After the third timeout, game_over=1 and mole_visible=0. A start pulse then restarts with score=0 and misses=0.
- Simultaneous correct and wrong bits in one cycle: score+1, misses unchanged. Wrong bit alone: misses+1, score unchanged.
- Score saturation: force 256 hits (score preloaded via 255 hits); score stays 255.

Source files
------------

// File: rtl/whack_a_mole_game_if.sv
// Player-input and game-status bundle between the whack-a-mole game core and
// its surroundings (buttons in, VGA/HEX status out).
interface whack_a_mole_game_if;
    logic       start;
    logic [3:0] whack;
    logic [1:0] mole_index;
    logic       mole_visible;
    logic [7:0] score;
    logic [2:0] misses;
    logic       game_over;

    modport master (
        input  start, whack,
        output mole_index, mole_visible, score, misses, game_over
    );

    modport slave (
        output start, whack,
        input  mole_index, mole_visible, score, misses, game_over
    );
endinterface

// File: rtl/whack_a_mole_game.sv
// Whack-a-mole game core: LFSR-driven mole choice, mole/gap window timing,
// button synchronisation, scoring and miss tracking.
module whack_a_mole_game #(
    parameter int          MOLE_CYCLES = 50000000,
    parameter int          GAP_CYCLES  = 12500000,
    parameter int          MAX_MISSES  = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic                 CLOCK_50,
    input logic                 reset,
    whack_a_mole_game_if.master bus
);
    typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

    localparam int T_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
    localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam logic [TW-1:0] MOLE_LOAD = TW'(MOLE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

    // bit 4 = start, bits 3:0 = whack; the pulse is registered once more
    // so a press sampled at edge N acts on the state at edge N+3
    logic [4:0] s1_q, s2_q, s3_q, pulse_q, pulse_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pulse_q <= '0;
        end else begin
            s1_q    <= {bus.start, bus.whack};
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= pulse_d;
        end
    end

    always_comb pulse_d = s2_q & ~s3_q;

    logic       start_p;
    logic [3:0] whack_p;
    assign start_p = pulse_q[4];
    assign whack_p = pulse_q[3:0];

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [1:0]    mole_index_q, mole_index_d;
    logic [7:0]    score_q, score_d;
    logic [2:0]    misses_q, misses_d;
    logic          mole_visible_q, mole_visible_d;
    logic          game_over_q, game_over_d;

    logic [1:0] cand, next_mole;
    logic       hit, wrong, timeout;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        mole_index_d = mole_index_q;
        score_d      = score_q;
        misses_d     = misses_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        cand      = lfsr_q[1:0];
        next_mole = (cand == mole_index_q) ? cand + 2'd1 : cand;
        hit       = whack_p[mole_index_q];
        wrong     = |(whack_p & ~(4'b0001 << mole_index_q));
        timeout   = (timer_q == '0);

        case (state_q)
            IDLE, OVER: begin
                if (start_p) begin
                    score_d      = '0;
                    misses_d     = '0;
                    mole_index_d = next_mole;
                    timer_d      = MOLE_LOAD;
                    state_d      = SHOW;
                end
            end
            SHOW: begin
                if (!timeout) timer_d = timer_q - TW'(1);
                // a hit wins over a simultaneous wrong press or timeout
                if (hit) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    timer_d = GAP_LOAD;
                    state_d = GAP;
                end else if (wrong || timeout) begin
                    misses_d = misses_q + 3'd1;
                    if (misses_d == 3'(MAX_MISSES)) begin
                        state_d = OVER;
                    end else begin
                        timer_d = GAP_LOAD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (timeout) begin
                    mole_index_d = next_mole;
                    timer_d      = MOLE_LOAD;
                    state_d      = SHOW;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        mole_visible_d = (state_d == SHOW);
        game_over_d    = (state_d == OVER);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            lfsr_q         <= LFSR_SEED;
            mole_index_q   <= '0;
            score_q        <= '0;
            misses_q       <= '0;
            mole_visible_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            lfsr_q         <= lfsr_d;
            mole_index_q   <= mole_index_d;
            score_q        <= score_d;
            misses_q       <= misses_d;
            mole_visible_q <= mole_visible_d;
            game_over_q    <= game_over_d;
        end
    end

    assign bus.mole_index   = mole_index_q;
    assign bus.mole_visible = mole_visible_q;
    assign bus.score        = score_q;
    assign bus.misses       = misses_q;
    assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_whack_a_mole_game.sv
// Bench for whack_a_mole_game: directed scenarios plus random presses, every
// cycle compared against an event-level model of the game rules.
module tb_whack_a_mole_game;
    localparam int MC = 20;
    localparam int GC = 4;
    localparam int MM = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_IDLE = 0, M_SHOW = 1, M_GAP = 2, M_OVER = 3;

    logic CLOCK_50 = 1'b0;
    logic reset;
    always #5 CLOCK_50 = ~CLOCK_50;

    whack_a_mole_game_if bus();

    whack_a_mole_game #(
        .MOLE_CYCLES(MC), .GAP_CYCLES(GC), .MAX_MISSES(MM), .LFSR_SEED(SEED)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // model: raw input history per edge, game state, absolute deadlines
    int          m_st, m_score, m_miss, m_mole, m_cyc, m_dl;
    logic [15:0] m_lfsr;
    logic [4:0]  hs [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int pick(input logic [15:0] l, input int cur);
        int c;
        c = int'(l[1:0]);
        return (c == cur) ? (c + 1) % 4 : c;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_score = 0; m_miss = 0; m_mole = 0; m_cyc = 0; m_dl = 0;
        m_lfsr = SEED;
        for (int i = 0; i < 5; i++) hs[i] = '0;
    endtask

    task automatic model_edge(input logic s, input logic [3:0] w);
        logic [4:0] p;
        logic [3:0] others;
        for (int i = 4; i > 0; i--) hs[i] = hs[i-1];
        hs[0] = {s, w};
        // a press sampled at edge k-3 acts at edge k, only on its rising sample
        p = hs[3] & ~hs[4];
        case (m_st)
            M_IDLE, M_OVER: if (p[4]) begin
                m_score = 0; m_miss = 0;
                m_mole = pick(m_lfsr, m_mole);
                m_dl = m_cyc + MC; m_st = M_SHOW;
            end
            M_SHOW: begin
                others = p[3:0] & ~(4'b0001 << m_mole);
                if (p[m_mole]) begin
                    if (m_score < 255) m_score++;
                    m_dl = m_cyc + GC; m_st = M_GAP;
                end else if (others != 0 || m_cyc == m_dl) begin
                    m_miss++;
                    if (m_miss == MM) m_st = M_OVER;
                    else begin m_dl = m_cyc + GC; m_st = M_GAP; end
                end
            end
            M_GAP: if (m_cyc == m_dl) begin
                m_mole = pick(m_lfsr, m_mole);
                m_dl = m_cyc + MC; m_st = M_SHOW;
            end
            default: ;
        endcase
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        m_cyc++;
    endtask

    task automatic compare_all(input string tag);
        logic [14:0] obs, exp;
        obs = {bus.mole_index, bus.mole_visible, bus.score, bus.misses, bus.game_over};
        exp = {2'(m_mole), m_st == M_SHOW, 8'(m_score), 3'(m_miss), m_st == M_OVER};
        check(tag, 32'(obs), 32'(exp));
    endtask

    // called at a negedge; inputs are sampled at the next posedge
    task automatic step(input logic s, input logic [3:0] w);
        bus.start = s;
        bus.whack = w;
        @(posedge CLOCK_50);
        model_edge(s, w);
        @(negedge CLOCK_50);
        compare_all("cycle");
    endtask

    task automatic apply_reset();
        bus.start = 1'b0;
        bus.whack = '0;
        reset = 1'b1;
        #1;
        check("rst_mole_index", 32'(bus.mole_index), 0);
        check("rst_visible", 32'(bus.mole_visible), 0);
        check("rst_score", 32'(bus.score), 0);
        check("rst_misses", 32'(bus.misses), 0);
        check("rst_game_over", 32'(bus.game_over), 0);
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
    endtask

    task automatic wait_vis();
        for (int i = 0; i < 64 && !bus.mole_visible; i++) step(1'b0, 4'h0);
        check("wait_visible", 32'(bus.mole_visible), 1);
    endtask

    task automatic hit();
        wait_vis();
        step(1'b0, 4'(4'b0001 << m_mole));
        for (int i = 0; i < 8 && bus.mole_visible; i++) step(1'b0, 4'h0);
    endtask

    initial begin
        int sb, mb, old, n, wr;
        bus.start = 1'b0;
        bus.whack = '0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        apply_reset();

        // start from IDLE: visible exactly three edges after sampling
        step(1'b0, 4'h0);
        step(1'b1, 4'h0);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        check("start_not_yet", 32'(bus.mole_visible), 0);
        step(1'b0, 4'h0);
        check("start_visible", 32'(bus.mole_visible), 1);
        check("start_mole", 32'(bus.mole_index), 32'(pick(SEED ^ SEED ^ m_lfsr, 0) * 0 + m_mole));
        check("start_score", 32'(bus.score), 0);
        check("start_misses", 32'(bus.misses), 0);

        // correct whack five cycles into SHOW
        repeat (4) step(1'b0, 4'h0);
        old = m_mole;
        step(1'b0, 4'(4'b0001 << old));
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        check("hit_score_early", 32'(bus.score), 0);
        step(1'b0, 4'h0);
        check("hit_score", 32'(bus.score), 1);
        check("gap_vis0", 32'(bus.mole_visible), 0);
        for (int i = 1; i < GC; i++) begin
            step(1'b0, 4'h0);
            check("gap_vis", 32'(bus.mole_visible), 0);
        end
        step(1'b0, 4'h0);
        check("gap_end_vis", 32'(bus.mole_visible), 1);
        check("new_mole_differs", 32'(bus.mole_index != 2'(old)), 1);

        // reach score 5, then reset asynchronously mid-SHOW
        repeat (4) hit();
        wait_vis();
        check("score_five", 32'(bus.score), 5);
        apply_reset();
        step(1'b0, 4'hF);
        repeat (8) step(1'b0, 4'h0);
        check("post_reset_score", 32'(bus.score), 0);
        check("post_reset_vis", 32'(bus.mole_visible), 0);

        // held button yields at most one pulse
        step(1'b1, 4'h0);
        wait_vis();
        sb = int'(bus.score);
        repeat (100) step(1'b0, 4'b0001);
        step(1'b0, 4'h0);
        check("held_score", 32'((int'(bus.score) - sb) <= 1), 1);

        // no presses: three 20-cycle moles time out, then game over
        apply_reset();
        step(1'b1, 4'h0);
        for (int k = 0; k < MM; k++) begin
            wait_vis();
            n = 0;
            while (bus.mole_visible && n < 40) begin
                step(1'b0, 4'h0);
                n++;
            end
            check("mole_len", 32'(n), 32'(MC));
            check("timeout_misses", 32'(bus.misses), 32'(k + 1));
        end
        check("over_flag", 32'(bus.game_over), 1);
        check("over_vis", 32'(bus.mole_visible), 0);
        step(1'b1, 4'h0);
        repeat (3) step(1'b0, 4'h0);
        check("restart_over", 32'(bus.game_over), 0);
        check("restart_score", 32'(bus.score), 0);
        check("restart_misses", 32'(bus.misses), 0);
        check("restart_vis", 32'(bus.mole_visible), 1);

        // correct plus wrong bit together, then wrong bit alone
        sb = int'(bus.score);
        mb = int'(bus.misses);
        wr = (m_mole + 1) % 4;
        step(1'b0, 4'((4'b0001 << m_mole) | (4'b0001 << wr)));
        repeat (3) step(1'b0, 4'h0);
        check("combo_score", 32'(bus.score), 32'(sb + 1));
        check("combo_misses", 32'(bus.misses), 32'(mb));
        wait_vis();
        wr = (m_mole + 1) % 4;
        step(1'b0, 4'(4'b0001 << wr));
        repeat (3) step(1'b0, 4'h0);
        check("wrong_misses", 32'(bus.misses), 32'(mb + 1));
        check("wrong_score", 32'(bus.score), 32'(sb + 1));

        // random presses against the model
        for (int i = 0; i < 400; i++) begin
            logic s;
            logic [3:0] w;
            s = ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step(s, w);
        end

        // score saturation
        apply_reset();
        step(1'b1, 4'h0);
        repeat (256) hit();
        check("sat_score", 32'(bus.score), 255);
        check("sat_misses", 32'(bus.misses), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
